// File: rtl/tx_fsm.sv
// tx_fsm: serial transmitter framing a 32-bit word as latch, 32 clocked bits and finish; define TX_FSM_MSB_FIRST_EN for MSB-first order
module tx_fsm #(
  parameter int DIV           = 1,
  parameter int LATCH_CYCLES  = 3,
  parameter int FINISH_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state_in,
  input  logic [31:0] transmit_data,
  output logic        data_tx,
  output logic        sck_tx,
  output logic        latch_flag,
  output logic        finish,
  output logic        finish_fsm,
  output logic        busy
);
  localparam int HW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int CM = LATCH_CYCLES > FINISH_CYCLES ? LATCH_CYCLES : FINISH_CYCLES;
  localparam int CW = CM > 1 ? $clog2(CM) : 1;
  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, FINISH} state_t;
  state_t        state_q;
  logic [31:0]   sr_q;
  logic [4:0]    bit_q;
  logic [HW-1:0] half_q;
  logic [CW-1:0] cnt_q;
  logic          next_bit;
  logic [31:0]   sr_shift;
`ifdef TX_FSM_MSB_FIRST_EN
  assign next_bit = sr_q[31];
  assign sr_shift = {sr_q[30:0], 1'b0};
`else
  assign next_bit = sr_q[0];
  assign sr_shift = {1'b0, sr_q[31:1]};
`endif
  // Frame sequencer: every output is a flop so the line pins never glitch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_q      <= '0;
      half_q     <= '0;
      cnt_q      <= '0;
      data_tx    <= 1'b0;
      sck_tx     <= 1'b0;
      latch_flag <= 1'b0;
      finish     <= 1'b0;
      finish_fsm <= 1'b0;
      busy       <= 1'b0;
    end else begin
      finish_fsm <= 1'b0;
      case (state_q)
        IDLE: if (state_in == 2'b01) begin
          state_q    <= LATCH;
          sr_q       <= transmit_data;
          cnt_q      <= '0;
          bit_q      <= '0;
          half_q     <= '0;
          latch_flag <= 1'b1;
          busy       <= 1'b1;
        end
        LATCH: if (cnt_q == CW'(LATCH_CYCLES - 1)) begin
          state_q    <= SHIFT;
          latch_flag <= 1'b0;
          sck_tx     <= 1'b1;
          data_tx    <= next_bit;
          sr_q       <= sr_shift;
        end else cnt_q <= cnt_q + 1'b1;
        SHIFT: if (half_q != HW'(DIV - 1)) half_q <= half_q + 1'b1;
        else begin
          half_q <= '0;
          if (sck_tx) sck_tx <= 1'b0;
          else if (bit_q == 5'd31) begin
            state_q <= FINISH;
            finish  <= 1'b1;
            data_tx <= 1'b0;
            cnt_q   <= '0;
          end else begin
            bit_q   <= bit_q + 1'b1;
            sck_tx  <= 1'b1;
            data_tx <= next_bit;
            sr_q    <= sr_shift;
          end
        end
        FINISH: if (cnt_q == CW'(FINISH_CYCLES - 1)) begin
          state_q    <= IDLE;
          finish     <= 1'b0;
          busy       <= 1'b0;
          finish_fsm <= 1'b1;
        end else cnt_q <= cnt_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_fsm.sv
// tb_tx_fsm: directed bench for tx_fsm (DIV=1 and DIV=2 instances), receiving on sck_tx falling edges
module tb_tx_fsm;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  st = 2'b00;
  logic [31:0] txd = '0;
  logic        sel = 1'b0;
  logic        a_d, a_s, a_l, a_f, a_ff, a_b;
  logic        b_d, b_s, b_l, b_f, b_ff, b_b;
  logic [5:0]  o, oa, ob;
  int          total = 0, bad = 0;
  int          lc, fc, bc, hi, rise, fall, lat2, pop, idx;
  int          ffs[$];
  logic        bits[$];
  logic [2:0]  first3;
  always #5 clk = ~clk;
  tx_fsm dut_a (
    .clk(clk), .rst(rst), .state_in(sel ? 2'b00 : st), .transmit_data(txd),
    .data_tx(a_d), .sck_tx(a_s), .latch_flag(a_l), .finish(a_f), .finish_fsm(a_ff), .busy(a_b)
  );
  tx_fsm #(.DIV(2)) dut_b (
    .clk(clk), .rst(rst), .state_in(sel ? st : 2'b00), .transmit_data(txd),
    .data_tx(b_d), .sck_tx(b_s), .latch_flag(b_l), .finish(b_f), .finish_fsm(b_ff), .busy(b_b)
  );
  assign oa = {a_d, a_s, a_l, a_f, a_ff, a_b};
  assign ob = {b_d, b_s, b_l, b_f, b_ff, b_b};
  assign o  = sel ? ob : oa;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] word_at(input int off);
    logic [31:0] w = '0;
    for (int k = 0; k < 32; k++)
      if (off + k < bits.size()) begin
`ifdef TX_FSM_MSB_FIRST_EN
        w[31-k] = bits[off+k];
`else
        w[k] = bits[off+k];
`endif
      end
    return w;
  endfunction
  function automatic int ff_at(input int i);
    return i < ffs.size() ? ffs[i] : -1;
  endfunction
  // Start a frame on the chosen instance and record what the line does for ncyc cycles
  task automatic run(input logic s, input logic [31:0] w, input int ncyc, input int inj, input logic [31:0] w2, input logic hold);
    logic ps = 1'b0, pl = 1'b0;
    bits.delete(); ffs.delete();
    lc = 0; fc = 0; bc = 0; hi = 0; rise = 0; fall = 0; lat2 = -1;
    @(posedge clk); #1;
    sel = s; st = 2'b01; txd = w;
    @(posedge clk); #1;
    if (!hold) st = 2'b00;
    txd = w2;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (o[3]) lc++;
      if (o[2]) fc++;
      if (o[0]) bc++;
      if (o[4]) hi++;
      if (o[1]) ffs.push_back(c);
      if (o[4] && !ps) rise++;
      if (!o[4] && ps) begin fall++; bits.push_back(o[5]); end
      if (o[3] && !pl && c > 1 && lat2 < 0) lat2 = c;
      ps = o[4];
      pl = o[3];
      if (c == inj) st = 2'b01;
      if (c == inj + 1 && !hold) st = 2'b00;
    end
    st = 2'b00;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_a", {58'd0, oa}, 64'd0);
    check("reset_b", {58'd0, ob}, 64'd0);
    #1 rst = 1'b1;
    run(1'b0, 32'd1_456_478_547, 76, -1, 32'h0, 1'b0);
    first3 = {bits[2], bits[1], bits[0]};
    check("t1_word", word_at(0), 32'd1_456_478_547);
`ifdef TX_FSM_MSB_FIRST_EN
    check("t1_first3", first3, 3'b010);
`else
    check("t1_first3", first3, 3'b011);
`endif
    check("t1_latch", lc, 3);
    check("t1_finish", fc, 5);
    check("t1_busy", bc, 72);
    check("t1_ff_n", ffs.size(), 1);
    check("t1_ff_cyc", ff_at(0), 73);
    check("t1_rise", rise, 32);
    check("t1_fall", fall, 32);
    check("t1_sck_hi", hi, 32);
    run(1'b0, 32'h1234_5678, 80, 30, 32'hFFFF_FFFF, 1'b0);
    check("t2_word", word_at(0), 32'h1234_5678);
    check("t2_ff_n", ffs.size(), 1);
    check("t2_ff_cyc", ff_at(0), 73);
    @(posedge clk); #1;
    sel = 1'b0; st = 2'b01; txd = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    st = 2'b00;
    repeat (20) @(negedge clk);
    check("t3_busy_pre", a_b, 1'b1);
    #1 rst = 1'b0;
    #1 check("t3_async_zero", {58'd0, oa}, 64'd0);
    pop = 0;
    repeat (2) begin @(negedge clk); if (a_ff) pop++; end
    #1 rst = 1'b1;
    repeat (80) begin @(negedge clk); if (a_ff || a_b) pop++; end
    check("t3_no_ff", pop, 0);
    run(1'b0, 32'hA5A5_0F0F, 76, -1, 32'h0, 1'b0);
    check("t3_word", word_at(0), 32'hA5A5_0F0F);
    check("t3_ff_cyc", ff_at(0), 73);
    run(1'b0, 32'hCAFE_BABE, 150, -1, 32'h0BAD_F00D, 1'b1);
    check("t4_ff0", ff_at(0), 73);
    check("t4_ff1", ff_at(1), 146);
    check("t4_latch2", lat2, 74);
    check("t4_word0", word_at(0), 32'hCAFE_BABE);
    check("t4_word1", word_at(32), 32'h0BAD_F00D);
    repeat (80) @(posedge clk);
    run(1'b1, 32'hFFFF_0001, 142, -1, 32'h0, 1'b0);
    check("t5_word", word_at(0), 32'hFFFF_0001);
    check("t5_busy", bc, 136);
    check("t5_ff_cyc", ff_at(0), 137);
    check("t5_sck_hi", hi, 64);
    check("t5_fall", fall, 32);
    run(1'b0, 32'h8000_0001, 76, -1, 32'h0, 1'b0);
    pop = 0;
    foreach (bits[i]) if (bits[i]) pop++;
    check("t6_first", bits.size() > 0 ? bits[0] : 1'bx, 1'b1);
    check("t6_last", bits.size() > 31 ? bits[31] : 1'bx, 1'b1);
    check("t6_pop", pop, 2);
    run(1'b0, 32'h4000_0000, 76, -1, 32'h0, 1'b0);
    idx = -1;
    foreach (bits[i]) if (bits[i] && idx < 0) idx = i;
`ifdef TX_FSM_MSB_FIRST_EN
    check("t6_pos", idx, 1);
`else
    check("t6_pos", idx, 30);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tx_fsm.md
# tx_fsm

Serial transmitter FSM; the sending end of the link whose receiving end is `rx_fsm`. On a start command it captures a 32-bit word. It then frames the word as a latch phase, 32 clocked data bits and a finish phase, driving `data_tx` together with a self-generated bit clock `sck_tx`. Sits between the parallel control logic (issuing `state_in`) and the serial line pins.

## Interface
- `DIV`, default 1: clk cycles per half period of `sck_tx` (≥1); one bit = 2·DIV cycles.
- `LATCH_CYCLES`, default 3: cycles `latch_flag` is held before the first bit (≥1).
- `FINISH_CYCLES`, default 5: cycles `finish` is held after the last bit (≥1).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `state_in`  in  2  command: 2'b01 = start, any other value = no-op.
- `transmit_data`  in  32  word to send; sampled only on the accepting edge.
- `data_tx`  out  1  serial data.
- `sck_tx`  out  1  bit clock; receiver samples `data_tx` on its falling edge.
- `latch_flag`  out  1  high during LATCH phase.
- `finish`  out  1  high during FINISH phase.
- `finish_fsm`  out  1  one-cycle pulse when frame completes.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE → LATCH → SHIFT → FINISH → IDLE.
- IDLE:
  - All outputs low.
  - `state_in==2'b01` at a rising edge loads `transmit_data` into a 32-bit shift register, clears counters and enters LATCH.
- LATCH:
  - `latch_flag`=1 for LATCH_CYCLES cycles.
  - `sck_tx`=0; `data_tx`=0.
  - Then enters SHIFT.
- SHIFT: 32 bit periods of 2·DIV cycles each.
  - At the start of each period: `data_tx` takes the next bit and `sck_tx` rises.
  - `sck_tx` stays high DIV cycles, then low DIV cycles.
  - Bit order is LSB first (bit 0 first).
  - A 5-bit bit counter and a half-period counter sized for DIV track position.
  - After the low half of bit 31, enters FINISH.
- FINISH:
  - `finish`=1 for FINISH_CYCLES cycles.
  - `sck_tx`=0; `data_tx`=0.
  - Then returns to IDLE with `finish_fsm`=1 for exactly that first IDLE cycle.
- `state_in` is ignored while `busy`=1; there is no queuing.
- A start presented in the same cycle that `finish_fsm`=1 is accepted (back-to-back frames).
- `transmit_data` changes after the accepting edge do not affect the frame in flight.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, shift register 0, counters 0.
  - All outputs 0: `data_tx`, `sck_tx`, `latch_flag`, `finish`, `finish_fsm`, `busy`.
- Reset mid-frame aborts immediately: outputs drop without waiting for a clock edge, and no `finish_fsm` is produced.
- Take the accepting edge as cycle 0. All outputs are registered.
  - Cycles 1..LATCH_CYCLES: `latch_flag`=1.
  - Bit k occupies cycles LATCH_CYCLES+1+2·DIV·k … LATCH_CYCLES+2·DIV·(k+1).
  - Then FINISH_CYCLES cycles of `finish`=1.
  - Next cycle: `finish_fsm`=1, `busy`=0.
- With defaults, one frame is 3+64+5 = 72 busy cycles, and `finish_fsm` is asserted in cycle 73.
- `busy` rises in cycle 1 and falls in the `finish_fsm` cycle.
- `sck_tx` produces exactly 32 rising and 32 falling edges per frame.

## Configuration
- `TX_FSM_MSB_FIRST_EN`
  - Defined: bits are sent MSB first (bit 31 first), shifting left.
  - Undefined (default): LSB first, shifting right, matching `rx_fsm`.
  - Framing and timing are identical in both builds.

## Test plan
- Default parameters, `rst` pulsed low 2 cycles, then one-cycle start with `transmit_data`=32'd1_456_478_547. Required response:
  - Word captured on `sck_tx` falling edges equals 1_456_478_547; first three bits are 1,1,0.
  - `latch_flag` high 3 cycles, `finish` high 5 cycles.
  - `finish_fsm` is a single pulse at cycle 73.
- Start re-asserted with a different word during SHIFT → ignored; the original word is sent and only one `finish_fsm` pulse occurs.
- `rst` low at cycle 20 of a frame → all outputs 0 asynchronously, no `finish_fsm`. A new start after release sends 32'hA5A5_0F0F correctly.
- Start held high continuously over 2 frames → frames run back-to-back: second LATCH begins the cycle after the first `finish_fsm`, and both words are received intact.
- DIV=2 with 32'hFFFF_0001 → each `sck_tx` half period is 2 cycles, frame is 3+128+5 busy cycles, received word is 32'hFFFF_0001.
- Build with `TX_FSM_MSB_FIRST_EN` and send 32'h8000_0001 → first and last transmitted bits are 1 and intervening bits are 0. A second word 32'h4000_0000 has second bit 1, confirming bit 31 goes first.
